// File: rtl/debug_pkg.sv
// Shared types and default widths for the debug step controller.
package debug_pkg;

   localparam int DBG_ADDR_W = 32;
   localparam int DBG_STEP_W = 8;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_HALT = 2'd1,
      ST_STEP = 2'd2
   } state_t;

endpackage

// File: rtl/step_sync.sv
// Synchroniser for the asynchronous debug_step level plus a registered rising-edge detector.
// Latency from input edge to step_pulse is SYNC_STAGES+1 clock cycles.
module step_sync
   import debug_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic step_level,
   output logic step_pulse
);

   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   prev_reg;
   logic                   pulse_reg;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_reg  <= '0;
         prev_reg  <= 1'b0;
         pulse_reg <= 1'b0;
      end else begin
         sync_reg  <= {sync_reg[SYNC_STAGES-2:0], step_level};
         prev_reg  <= sync_reg[SYNC_STAGES-1];
         pulse_reg <= sync_reg[SYNC_STAGES-1] & ~prev_reg;
      end
   end

   assign step_pulse = pulse_reg;

endmodule

// File: rtl/debug_step_ctrl.sv
// Run / halt / N-cycle step controller with PC breakpoints, gating the CPU clock enable.
// Optional executed-cycle counter enabled by defining DEBUG_STEP_CYCLE_CNT_EN.
module debug_step_ctrl
   import debug_pkg::*;
#(
   parameter int ADDR_W      = DBG_ADDR_W,
   parameter int STEP_W      = DBG_STEP_W,
   parameter int NUM_BP      = 2,
   parameter int SYNC_STAGES = 2
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     debug_en,
   input  logic                     debug_step,
   input  logic [STEP_W-1:0]        step_count,
   input  logic [ADDR_W-1:0]        pc,
   input  logic [NUM_BP*ADDR_W-1:0] bp_addr,
   input  logic [NUM_BP-1:0]        bp_valid,
   output logic                     cpu_en,
   output logic                     halted,
   output logic                     step_done,
   output logic [NUM_BP-1:0]        bp_hit,
   output logic [31:0]              cycle_cnt
);

   state_t            state_reg, state_next;
   logic [STEP_W-1:0] counter_reg, counter_next;
   logic              skip_reg, skip_next;
   logic              cpu_en_reg, cpu_en_next;
   logic              halted_reg, halted_next;
   logic              step_done_reg, step_done_next;
   logic [NUM_BP-1:0] bp_hit_reg, bp_hit_next;
   logic [NUM_BP-1:0] match;
   logic              hit;
   logic              step_pulse;

   step_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_step_sync (
      .clock      (clock),
      .reset      (reset),
      .step_level (debug_step),
      .step_pulse (step_pulse)
   );

   for (genvar gi = 0; gi < NUM_BP; gi++) begin : g_bp
      assign match[gi] = bp_valid[gi] && (pc == bp_addr[gi*ADDR_W +: ADDR_W]);
   end

   // A hit must suppress the matching instruction in the same cycle, so the
   // registered enable is masked by the live comparison.
   assign hit    = cpu_en_reg && !skip_reg && (|match);
   assign cpu_en = cpu_en_reg && !hit;

   always_comb begin
      state_next     = state_reg;
      counter_next   = counter_reg;
      skip_next      = skip_reg;
      bp_hit_next    = bp_hit_reg;
      step_done_next = 1'b0;

      if (cpu_en_reg)
         skip_next = 1'b0;

      unique case (state_reg)
         ST_RUN: begin
            if (hit) begin
               state_next  = ST_HALT;
               bp_hit_next = match;
            end else if (debug_en) begin
               state_next = ST_HALT;
            end
         end
         ST_HALT: begin
            if (!debug_en) begin
               state_next = ST_RUN;
               skip_next  = 1'b1;
            end else if (step_pulse) begin
               state_next   = ST_STEP;
               counter_next = (step_count == '0) ? STEP_W'(1) : step_count;
               skip_next    = 1'b1;
               bp_hit_next  = '0;
            end
         end
         ST_STEP: begin
            if (!debug_en) begin
               state_next = ST_RUN;
               skip_next  = 1'b1;
            end else if (hit) begin
               state_next     = ST_HALT;
               step_done_next = 1'b1;
               bp_hit_next    = match;
            end else if (counter_reg <= STEP_W'(1)) begin
               state_next     = ST_HALT;
               step_done_next = 1'b1;
            end else begin
               counter_next = counter_reg - STEP_W'(1);
            end
         end
         default: state_next = ST_HALT;
      endcase

      cpu_en_next = (state_next != ST_HALT);
      halted_next = (state_next == ST_HALT);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg     <= ST_HALT;
         counter_reg   <= '0;
         skip_reg      <= 1'b0;
         cpu_en_reg    <= 1'b0;
         halted_reg    <= 1'b1;
         step_done_reg <= 1'b0;
         bp_hit_reg    <= '0;
      end else begin
         state_reg     <= state_next;
         counter_reg   <= counter_next;
         skip_reg      <= skip_next;
         cpu_en_reg    <= cpu_en_next;
         halted_reg    <= halted_next;
         step_done_reg <= step_done_next;
         bp_hit_reg    <= bp_hit_next;
      end
   end

   assign halted    = halted_reg;
   assign step_done = step_done_reg;
   assign bp_hit    = bp_hit_reg;

`ifdef DEBUG_STEP_CYCLE_CNT_EN
   logic [31:0] cycle_cnt_reg;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         cycle_cnt_reg <= 32'h0;
      else if (cpu_en)
         cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
   end

   assign cycle_cnt = cycle_cnt_reg;
`else
   assign cycle_cnt = 32'h0;
`endif

endmodule
